perf_window_ctrl: RTL and testbench
===================================

Name: perf_window_ctrl

Overview:
- Measurement-window controller and sampler for the mcycle/minstret performance counters in the CVA6 testbench/APU.
- Sequences start/stop of a measurement region and optionally takes periodic interval samples.
- Computes cycle and instruction deltas for each sample, buffers them as records, and hands them to a downstream logger/consumer over a valid/ready interface.

Parameters:
- CNT_W, 64, width of counter inputs and delta outputs.
- INTERVAL_W, 32, width of the periodic-sample interval.
- FIFO_DEPTH, 4, number of buffered sample records; power of 2, at least 2.
- SEQ_W, 16, width of the sample sequence number.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mcycle_i  in  CNT_W  current mcycle value (RV32 hi/lo already concatenated).
- minstret_i  in  CNT_W  current minstret value.
- start_i  in  1  single-cycle pulse; opens a window.
- stop_i  in  1  single-cycle pulse; closes the window.
- interval_i  in  INTERVAL_W  periodic sample interval in cycles; 0 disables periodic sampling. Sampled at start.
- sample_valid_o  out  1  record available at FIFO head.
- sample_ready_i  in  1  consumer accepts the head record.
- sample_cycles_o  out  CNT_W  mcycle delta of the head record.
- sample_instrs_o  out  CNT_W  minstret delta of the head record.
- sample_seq_o  out  SEQ_W  sequence number of the head record.
- sample_final_o  out  1  head record is the closing record of the window.
- drop_cnt_o  out  SEQ_W  periodic records lost to a full FIFO; saturating.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0; FSM = IDLE; FIFO empty; base registers, timer and seq all 0.
  - Reset mid-window discards all buffered records; no final record is produced.
- FSM states: IDLE, MEASURE, STOP_PEND, FLUSH.
- IDLE:
  - start_i latches base_cyc = mcycle_i, base_ins = minstret_i, timer = interval_i, ival = interval_i, and seq = 0; next state MEASURE.
  - stop_i in IDLE is ignored.
- MEASURE, periodic tick:
  - When ival != 0, timer decrements by 1 each cycle. A tick occurs when timer == 1, i.e. exactly ival cycles after start or after the previous tick.
  - On a tick: push record {mcycle_i - base_cyc, minstret_i - base_ins, seq, final = 0}; base <= current counters; seq += 1; timer <= ival.
- MEASURE, stop:
  - stop_i computes the final record {deltas vs. base, seq, final = 1}.
  - If the FIFO has space: push it and go to FLUSH.
  - Otherwise: hold the record in a pending register and go to STOP_PEND.
- MEASURE, start_i: ignored (no restart).
- Simultaneous tick and stop: only the final record is pushed. Its deltas cover the span from the last base. seq is not double-incremented.
- STOP_PEND: push the pending record on the first cycle the FIFO has space, then go to FLUSH. A final record is never dropped.
- FLUSH: go to IDLE on the cycle the FIFO becomes empty. start_i is ignored until IDLE.
- Arithmetic:
  - Deltas are modulo 2^CNT_W subtractions, so counter wrap yields the correct small delta.
  - seq wraps modulo 2^SEQ_W.
- FIFO:
  - First-word-fall-through. A record pushed in cycle N is visible on the outputs in cycle N+1.
  - Pop occurs when sample_valid_o && sample_ready_i.
  - Push into a full FIFO is accepted if a pop happens in the same cycle.
  - A periodic push into a full FIFO with no pop: record dropped, base and seq still advance, drop_cnt_o += 1 (saturates at 2^SEQ_W-1).
  - drop_cnt_o clears only on reset or on the next start_i.
- Output data is stable while sample_valid_o is high and sample_ready_i is low.

Decomposition:
- Package perf_pkg holds:
  - perf_sample_t struct {cycles, instrs, seq, final}, parameterised by CNT_W/SEQ_W via localparams.
  - The FSM state enum perf_win_state_e.
- One sub-module: perf_sample_fifo, a generic FWFT FIFO of perf_sample_t with push/pop/full/empty. Controller, timer and delta datapath stay in perf_window_ctrl.

Test Plan:
- Basic window: interval_i = 0, start at mcycle 100 / minstret 40, stop at mcycle 350 / minstret 190, ready = 1 → one record: cycles 250, instrs 150, seq 0, final 1; busy_o drops 1 cycle after the pop.
- Periodic sampling: interval_i = 10, counters +1 cycle and +1 instr per clk, stop 35 cycles after start → records seq 0/1/2 with cycles 10/10/10, then seq 3 final with cycles 5.
- Backpressure/drop: interval_i = 2, ready = 0 for 20 cycles, FIFO_DEPTH = 4 → 4 records held, drop_cnt_o = 6; stop then ready = 1 → final record is delivered after the 4 held records with its seq following the last dropped seq.
- Tick and stop together: interval_i = 5, stop exactly on the tick cycle → single final record, cycles 5, no extra periodic record.
- Counter wrap: base mcycle 0xFFFF_FFFF_FFFF_FFF0, stop at 0x10 → cycles 0x20.
- Reset mid-window: rst_i asserted in MEASURE with 2 records queued → next cycle sample_valid_o = 0, busy_o = 0, drop_cnt_o = 0; a subsequent start/stop yields seq 0.

Source files
------------

// File: rtl/perf_pkg.sv
// ----------------------------------------------------------------------------
// perf_pkg
// Shared types for the performance-window controller: the buffered sample
// record and the controller FSM state encoding.
// ----------------------------------------------------------------------------
package perf_pkg;

    localparam int PERF_CNT_W = 64;
    localparam int PERF_SEQ_W = 16;

    // One measurement record as held in the sample FIFO.
    typedef struct packed {
        logic [PERF_CNT_W-1:0] cycles;
        logic [PERF_CNT_W-1:0] instrs;
        logic [PERF_SEQ_W-1:0] seq;
        logic                  is_final;
    } perf_sample_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEASURE   = 2'd1,
        STOP_PEND = 2'd2,
        FLUSH     = 2'd3
    } perf_win_state_e;

endpackage

// File: rtl/perf_sample_fifo.sv
// ----------------------------------------------------------------------------
// perf_sample_fifo
// First-word-fall-through FIFO of perf_sample_t records. A word pushed in one
// cycle is visible at data_o in the next. A push into a full FIFO is taken
// only when a pop happens in the same cycle.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/data_i  write request and record
//   pop_i          consume head record (ignored when empty)
//   data_o         head record (zero when empty)
//   full_o         DEPTH records held
//   empty_o        no record held
//   last_o         exactly one record held
// ----------------------------------------------------------------------------
import perf_pkg::*;

module perf_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = $bits(perf_sample_t)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         last_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == FULL_CNT);
    assign last_o  = (r_count == (AW+1)'(1));

    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    // Masked so the head reads as zero whenever nothing is buffered.
    assign data_o = empty_o ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the output mask hides stale entries.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/perf_window_ctrl.sv
// ----------------------------------------------------------------------------
// perf_window_ctrl
// Measurement-window controller for mcycle/minstret. Opens a window on
// start_i, optionally emits periodic interval records, closes with a final
// record on stop_i and hands records to a consumer via valid/ready.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mcycle_i, minstret_i  live counter values
//   start_i, stop_i       window open / close pulses
//   interval_i            periodic interval in cycles (0 = off), taken at start
//   sample_*_o            head record: valid, cycles, instrs, seq, final
//   sample_ready_i        consumer accepts head record
//   drop_cnt_o            periodic records lost to a full FIFO (saturating)
//   busy_o                controller not idle
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start_i
// MEASURE   | window open, periodic ticks active
// STOP_PEND | final record held until the FIFO has room
// FLUSH     | window closed, draining FIFO before returning to IDLE
// ----------------------------------------------------------------------------
import perf_pkg::*;

module perf_window_ctrl #(
    parameter int CNT_W      = PERF_CNT_W,
    parameter int INTERVAL_W = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = PERF_SEQ_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CNT_W-1:0]      mcycle_i,
    input  logic [CNT_W-1:0]      minstret_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic [CNT_W-1:0]      sample_cycles_o,
    output logic [CNT_W-1:0]      sample_instrs_o,
    output logic [SEQ_W-1:0]      sample_seq_o,
    output logic                  sample_final_o,
    output logic [SEQ_W-1:0]      drop_cnt_o,
    output logic                  busy_o
);

    localparam int REC_W = $bits(perf_sample_t);

    perf_win_state_e       r_state;
    logic [CNT_W-1:0]      r_base_cyc;
    logic [CNT_W-1:0]      r_base_ins;
    logic [INTERVAL_W-1:0] r_timer;
    logic [INTERVAL_W-1:0] r_ival;
    logic [SEQ_W-1:0]      r_seq;
    logic [SEQ_W-1:0]      r_drop;
    perf_sample_t          r_pend;

    perf_sample_t w_rec;
    perf_sample_t w_push_rec;
    perf_sample_t w_head;
    logic [REC_W-1:0] w_head_bits;
    logic w_full;
    logic w_empty;
    logic w_last;
    logic w_pop;
    logic w_space;
    logic w_tick;
    logic w_push;

    // Deltas against the current base; modulo arithmetic handles wrap.
    always_comb begin
        w_rec.cycles   = mcycle_i - r_base_cyc;
        w_rec.instrs   = minstret_i - r_base_ins;
        w_rec.seq      = r_seq;
        w_rec.is_final = stop_i;
    end

    assign w_pop   = !w_empty && sample_ready_i;
    assign w_space = !w_full || w_pop;
    assign w_tick  = (r_state == MEASURE) && (r_ival != '0) &&
                     (r_timer == INTERVAL_W'(1));

    // A stop coinciding with a tick pushes only the final record.
    always_comb begin
        w_push     = 1'b0;
        w_push_rec = w_rec;
        case (r_state)
            MEASURE:   w_push = (stop_i || w_tick) && w_space;
            STOP_PEND: begin
                w_push     = w_space;
                w_push_rec = r_pend;
            end
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_base_cyc <= '0;
            r_base_ins <= '0;
            r_timer    <= '0;
            r_ival     <= '0;
            r_seq      <= '0;
            r_drop     <= '0;
            r_pend     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_base_cyc <= mcycle_i;
                        r_base_ins <= minstret_i;
                        r_timer    <= interval_i;
                        r_ival     <= interval_i;
                        r_seq      <= '0;
                        r_drop     <= '0;
                        r_state    <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (stop_i) begin
                        if (!w_space) begin
                            r_pend  <= w_rec;
                            r_state <= STOP_PEND;
                        end else begin
                            r_state <= FLUSH;
                        end
                    end else if (r_ival != '0) begin
                        if (w_tick) begin
                            r_timer    <= r_ival;
                            r_base_cyc <= mcycle_i;
                            r_base_ins <= minstret_i;
                            r_seq      <= r_seq + 1'b1;
                            if (!w_space && (r_drop != '1))
                                r_drop <= r_drop + 1'b1;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                end
                STOP_PEND: begin
                    if (w_space) r_state <= FLUSH;
                end
                FLUSH: begin
                    // Leave on the cycle the last record is popped.
                    if (w_empty || (w_last && w_pop)) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    perf_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_push_rec),
        .pop_i   (sample_ready_i),
        .data_o  (w_head_bits),
        .full_o  (w_full),
        .empty_o (w_empty),
        .last_o  (w_last)
    );

    assign w_head          = perf_sample_t'(w_head_bits);
    assign sample_valid_o  = !w_empty;
    assign sample_cycles_o = w_head.cycles;
    assign sample_instrs_o = w_head.instrs;
    assign sample_seq_o    = w_head.seq;
    assign sample_final_o  = w_head.is_final;
    assign drop_cnt_o      = r_drop;
    assign busy_o          = (r_state != IDLE);

endmodule

// File: tb/tb_perf_window_ctrl.sv
module tb_perf_window_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] cyc;
        logic [63:0] ins;
        logic [15:0] seq;
        logic        fin;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mcycle = '0;
    logic [63:0] minstret = '0;
    logic [63:0] ins_inc = 64'd1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] interval = '0;
    logic        ready = 1'b1;

    logic        sample_valid_o;
    logic [63:0] sample_cycles_o;
    logic [63:0] sample_instrs_o;
    logic [15:0] sample_seq_o;
    logic        sample_final_o;
    logic [15:0] drop_cnt_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    perf_window_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mcycle_i        (mcycle),
        .minstret_i      (minstret),
        .start_i         (start),
        .stop_i          (stop),
        .interval_i      (interval),
        .sample_valid_o  (sample_valid_o),
        .sample_ready_i  (ready),
        .sample_cycles_o (sample_cycles_o),
        .sample_instrs_o (sample_instrs_o),
        .sample_seq_o    (sample_seq_o),
        .sample_final_o  (sample_final_o),
        .drop_cnt_o      (drop_cnt_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 window open, 2 final record waiting, 3 draining
    int          m_mode = 0;
    logic [63:0] m_bc = '0;
    logic [63:0] m_bi = '0;
    int unsigned m_ival = 0;
    int unsigned m_el = 0;
    logic [15:0] m_seq = '0;
    logic [15:0] m_drop = '0;
    rec_t        m_q[$];
    rec_t        m_pend;
    rec_t        m_log[$];

    always @(posedge clk or posedge rst) begin
        bit   pop;
        bit   space;
        rec_t r;
        if (rst) begin
            m_mode = 0;
            m_q.delete();
            m_bc = '0; m_bi = '0; m_ival = 0; m_el = 0;
            m_seq = '0; m_drop = '0;
        end else begin
            pop   = ready && (m_q.size() > 0);
            space = (m_q.size() < DEPTH) || pop;
            if (pop) m_log.push_back(m_q.pop_front());
            case (m_mode)
                0: if (start) begin
                    m_bc = mcycle; m_bi = minstret; m_ival = interval;
                    m_el = 0; m_seq = '0; m_drop = '0; m_mode = 1;
                end
                1: begin
                    m_el++;
                    r.cyc = mcycle - m_bc;
                    r.ins = minstret - m_bi;
                    r.seq = m_seq;
                    if (stop) begin
                        r.fin = 1'b1;
                        if (space) begin m_q.push_back(r); m_mode = 3; end
                        else begin m_pend = r; m_mode = 2; end
                    end else if (m_ival != 0 && m_el == m_ival) begin
                        r.fin = 1'b0;
                        if (space) m_q.push_back(r);
                        else if (m_drop != 16'hFFFF) m_drop++;
                        m_bc = mcycle; m_bi = minstret; m_seq++; m_el = 0;
                    end
                end
                2: if (space) begin m_q.push_back(m_pend); m_mode = 3; end
                default: if (m_q.size() == 0) m_mode = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        check64("valid", sample_valid_o, m_q.size() > 0);
        check64("busy", busy_o, m_mode != 0);
        check64("drop_cnt", drop_cnt_o, m_drop);
        if (m_q.size() > 0) begin
            check64("head_cycles", sample_cycles_o, m_q[0].cyc);
            check64("head_instrs", sample_instrs_o, m_q[0].ins);
            check64("head_seq", sample_seq_o, m_q[0].seq);
            check64("head_final", sample_final_o, m_q[0].fin);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic p);
        @(negedge clk);
        mcycle   += 64'd1;
        minstret += ins_inc;
        start = s;
        stop  = p;
    endtask

    task automatic step_at(input logic [63:0] mc, input logic [63:0] mi, input logic s, input logic p);
        @(negedge clk);
        mcycle   = mc;
        minstret = mi;
        start = s;
        stop  = p;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        step(1'b0, 1'b0);
        while (busy_o && n < 300) begin
            step(1'b0, 1'b0);
            n++;
        end
        total++;
        if (busy_o) begin
            bad++;
            $display("FAIL %s_timeout: busy got 1 want 0", name);
        end
    endtask

    task automatic chk_rec(input string name, input int idx, input logic [63:0] c,
                           input logic [63:0] i, input logic [15:0] s, input logic f);
        if (idx >= m_log.size()) begin
            total++;
            bad++;
            $display("FAIL %s: record missing, log size %0d want > %0d", name, m_log.size(), idx);
        end else begin
            check64({name, "_cycles"}, m_log[idx].cyc, c);
            check64({name, "_instrs"}, m_log[idx].ins, i);
            check64({name, "_seq"}, m_log[idx].seq, 64'(s));
            check64({name, "_final"}, m_log[idx].fin, 64'(f));
        end
    endtask

    initial begin
        int b;
        repeat (2) @(negedge clk);
        check64("rst_valid", sample_valid_o, 0);
        check64("rst_busy", busy_o, 0);
        check64("rst_drop", drop_cnt_o, 0);
        check64("rst_cycles", sample_cycles_o, 0);
        check64("rst_seq", sample_seq_o, 0);
        rst = 1'b0;

        // Basic window
        b = m_log.size();
        ready = 1'b1; interval = 0; ins_inc = 64'd1;
        step_at(64'd100, 64'd40, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        step_at(64'd350, 64'd190, 1'b0, 1'b1);
        wait_idle("basic");
        chk_rec("basic_r0", b, 64'd250, 64'd150, 16'd0, 1'b1);
        check64("basic_count", m_log.size() - b, 1);

        // Periodic sampling every 10 cycles, stop 35 cycles after start
        b = m_log.size();
        interval = 10;
        step(1'b1, 1'b0);
        repeat (34) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_idle("periodic");
        for (int k = 0; k < 3; k++)
            chk_rec($sformatf("periodic_r%0d", k), b + k, 64'd10, 64'd10, 16'(k), 1'b0);
        chk_rec("periodic_r3", b + 3, 64'd5, 64'd5, 16'd3, 1'b1);
        check64("periodic_count", m_log.size() - b, 4);

        // Backpressure: interval 2, consumer stalled for 20 cycles
        b = m_log.size();
        interval = 2; ready = 1'b0;
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check64("bp_drop_dut", drop_cnt_o, 6);
        check64("bp_drop_model", m_drop, 6);
        ready = 1'b1;
        wait_idle("bp");
        for (int k = 0; k < 4; k++)
            chk_rec($sformatf("bp_r%0d", k), b + k, 64'd2, 64'd2, 16'(k), 1'b0);
        chk_rec("bp_final", b + 4, 64'd1, 64'd1, 16'd10, 1'b1);
        check64("bp_count", m_log.size() - b, 5);

        // Stop on the exact tick cycle
        b = m_log.size();
        interval = 5;
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_idle("tickstop");
        chk_rec("tickstop_r0", b, 64'd5, 64'd5, 16'd0, 1'b1);
        check64("tickstop_count", m_log.size() - b, 1);

        // Counter wrap
        b = m_log.size();
        interval = 0; ins_inc = 64'd3;
        step_at(64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 1'b1, 1'b0);
        repeat (31) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check64("wrap_mcycle_at_stop", mcycle, 64'h10);
        wait_idle("wrap");
        chk_rec("wrap_r0", b, 64'h20, 64'd96, 16'd0, 1'b1);

        // Reset mid-window with two records queued
        ins_inc = 64'd1; interval = 3; ready = 1'b0;
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        check64("rstmid_queued", sample_valid_o, 1);
        check64("rstmid_model_q", m_q.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        check64("rstmid_valid", sample_valid_o, 0);
        check64("rstmid_busy", busy_o, 0);
        check64("rstmid_drop", drop_cnt_o, 0);
        rst = 1'b0;
        b = m_log.size();
        ready = 1'b1; interval = 0;
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_idle("rstmid");
        chk_rec("rstmid_r0", b, 64'd4, 64'd4, 16'd0, 1'b1);
        check64("rstmid_count", m_log.size() - b, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
